matrix_mul_seq: RTL and testbench
=================================

MATRIX_MUL_SEQ -- requirements
Module: matrix_mul_seq

Interface
REQ-001 The block SHALL have parameter MAX_DIM, default 5, maximum rows/columns per matrix.
REQ-002 The block SHALL have parameter DATA_W, default 8, unsigned input element width.
REQ-003 The block SHALL have parameter ACC_W, default 16, unsigned result element width.
REQ-004 The block SHALL have parameter DIM_W, default 3, width of every dimension port.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 The block SHALL have port start, input, 1, request pulse; accepted only while busy=0.
REQ-008 The block SHALL have ports a_m, a_n, b_m, b_n, input, DIM_W each, giving A rows/cols and B rows/cols.
REQ-009 The block SHALL have ports matrixA and matrixB, input, MAX_DIM*MAX_DIM*DATA_W each; element (r,c) occupies bits [(r*MAX_DIM+c)*DATA_W +: DATA_W].
REQ-010 The block SHALL have port busy, output, 1, high from acceptance until done.
REQ-011 The block SHALL have port done, output, 1, one-cycle completion pulse.
REQ-012 The block SHALL have ports valid and mulError, output, 1 each, status of the last completed request.
REQ-013 The block SHALL have ports c_m and c_n, output, DIM_W each, result dimensions.
REQ-014 The block SHALL have port aMulB, output, MAX_DIM*MAX_DIM*ACC_W, result; element (r,c) occupies bits [(r*MAX_DIM+c)*ACC_W +: ACC_W].

Function
REQ-015 On an accepted start, the block SHALL register all dims and both matrices; later input changes SHALL have no effect on the running request.
REQ-016 The FSM SHALL use states IDLE, CHECK, MAC, FIN; IDLE->CHECK on accepted start; CHECK->MAC if dims are legal, else CHECK->FIN with error; MAC->FIN after the last MAC; FIN->IDLE unconditionally.
REQ-017 Dims SHALL be legal iff a_n==b_m and a_m, a_n, b_n are each in 1..MAX_DIM.
REQ-018 In MAC, the block SHALL perform exactly one DATA_W x DATA_W multiply-accumulate per cycle, iterating k innermost, then j, then i, for N=a_m*a_n*b_n cycles.
REQ-019 The full-width product SHALL be added to the accumulator; the accumulator result SHALL be written to element (i,j) when k reaches a_n-1.
REQ-020 For a legal request, done SHALL pulse exactly N+2 cycles after the start acceptance edge; for an illegal request, exactly 2 cycles after it.
REQ-021 In FIN, the block SHALL assert done for one cycle; on success valid=1, mulError=0, c_m=a_m, c_n=b_n; on error valid=0, mulError=1, c_m=c_n=0, aMulB all zero.
REQ-022 Result elements outside c_m x c_n SHALL be zero.
REQ-023 valid, mulError, c_m, c_n and aMulB SHALL hold until the next accepted start, which SHALL clear valid and mulError in the acceptance cycle.
REQ-024 A start while busy=1 SHALL be ignored with no effect on the running request.
REQ-025 A start in the FIN cycle SHALL be ignored; a start in the following IDLE cycle SHALL be accepted.

Reset
REQ-026 When reset is high at a clock edge, the FSM SHALL return to IDLE, and busy, done, valid, mulError, c_m, c_n, aMulB and all counters and accumulators SHALL become 0.
REQ-027 Reset mid-operation SHALL abandon the request with no done pulse; reset SHALL take priority over a simultaneous start.

Configuration
REQ-028 With macro MATMUL_SATURATE_EN defined, the accumulator SHALL clamp to 2^ACC_W-1 on overflow and stay clamped for the rest of that element.
REQ-029 Without MATMUL_SATURATE_EN, accumulation SHALL wrap modulo 2^ACC_W.

Verification
REQ-030 Test 1: A=2x3 [1 2 3; 3 4 5], B=3x2 [1 0; 2 1; 3 2], start -> done 14 cycles later; valid=1, C=2x2 [14 8; 26 14], all other elements 0.
REQ-031 Test 2: a_m=2, a_n=3, b_m=2, b_n=2, start -> done 2 cycles later; mulError=1, valid=0, c_m=c_n=0.
REQ-032 Test 3: A=1x5 and B=5x1, all elements 255 -> C(0,0)=65535 with MATMUL_SATURATE_EN; 62981 without it.
REQ-033 Test 4: 5x5 x 5x5 with all elements 1 -> done 127 cycles later; every element 5; a second start during busy is ignored.
REQ-034 Test 5: reset high 3 cycles into Test 1 -> no done pulse, all outputs 0; a new start afterwards returns the correct Test 1 result.

Source files
------------

// File: rtl/matrix_mul_seq.sv
// matrix_mul_seq: sequential matrix multiplier, C = A x B, one MAC per cycle.
// Operands and dimensions are captured when a request is accepted; the result
// and status registers hold until the next accepted request.
// Optional feature: define MATMUL_SATURATE_EN to clamp each result element at
// 2^ACC_W-1 instead of wrapping modulo 2^ACC_W.
//
// state | meaning
// IDLE  | waiting for start; previous result/status held
// CHECK | validating the captured dimensions
// MAC   | one multiply-accumulate per cycle, k innermost, then j, then i
// FIN   | publish status; done pulses on the way back to IDLE
module matrix_mul_seq #(
    parameter int MAX_DIM = 5,
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 16,
    parameter int DIM_W   = 3
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [DIM_W-1:0]                   a_m,
    input  logic [DIM_W-1:0]                   a_n,
    input  logic [DIM_W-1:0]                   b_m,
    input  logic [DIM_W-1:0]                   b_n,
    input  logic [MAX_DIM*MAX_DIM*DATA_W-1:0]  matrixA,
    input  logic [MAX_DIM*MAX_DIM*DATA_W-1:0]  matrixB,
    output logic                               busy,
    output logic                               done,
    output logic                               valid,
    output logic                               mulError,
    output logic [DIM_W-1:0]                   c_m,
    output logic [DIM_W-1:0]                   c_n,
    output logic [MAX_DIM*MAX_DIM*ACC_W-1:0]   aMulB
);

    localparam int ELEMS  = MAX_DIM * MAX_DIM;
    localparam int IDX_W  = (ELEMS > 1) ? $clog2(ELEMS) : 1;
    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        MAC   = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t state, state_next;

    logic [DIM_W-1:0]  a_m_r, a_n_r, b_m_r, b_n_r;
    logic [DATA_W-1:0] a_mem [ELEMS];
    logic [DATA_W-1:0] b_mem [ELEMS];
    logic [ACC_W-1:0]  c_mem [ELEMS];
    logic [DIM_W-1:0]  idx_i, idx_j, idx_k;
    logic [ACC_W-1:0]  acc;
    logic              err;

    logic              dims_legal;
    logic              k_last, j_last, i_last, mac_last;
    logic [IDX_W-1:0]  a_idx, b_idx, c_idx;
    logic [PROD_W-1:0] prod;
    logic [ACC_W-1:0]  acc_base;
    logic [SUM_W-1:0]  sum;
    logic [ACC_W-1:0]  acc_new;

    // Dimension check on the captured request
    always_comb begin
        dims_legal = (a_n_r == b_m_r)
                  && (a_m_r != '0) && (a_m_r <= DIM_W'(MAX_DIM))
                  && (a_n_r != '0) && (a_n_r <= DIM_W'(MAX_DIM))
                  && (b_n_r != '0) && (b_n_r <= DIM_W'(MAX_DIM));
    end

    // Loop-end flags and the multiply-accumulate datapath for the current (i,j,k)
    always_comb begin
        k_last   = (idx_k == a_n_r - DIM_W'(1));
        j_last   = (idx_j == b_n_r - DIM_W'(1));
        i_last   = (idx_i == a_m_r - DIM_W'(1));
        mac_last = k_last && j_last && i_last;
        a_idx    = IDX_W'(idx_i) * IDX_W'(MAX_DIM) + IDX_W'(idx_k);
        b_idx    = IDX_W'(idx_k) * IDX_W'(MAX_DIM) + IDX_W'(idx_j);
        c_idx    = IDX_W'(idx_i) * IDX_W'(MAX_DIM) + IDX_W'(idx_j);
        prod     = PROD_W'(a_mem[a_idx]) * PROD_W'(b_mem[b_idx]);
        // k==0 starts a fresh element, so the stale accumulator is ignored
        acc_base = (idx_k == '0) ? '0 : acc;
        sum      = SUM_W'(acc_base) + SUM_W'(prod);
`ifdef MATMUL_SATURATE_EN
        // Once clamped, acc_base is all ones and any further product keeps it clamped
        acc_new  = (sum[SUM_W-1:ACC_W] != '0) ? '1 : sum[ACC_W-1:0];
`else
        acc_new  = sum[ACC_W-1:0];
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CHECK;
            CHECK:   state_next = dims_legal ? MAC : FIN;
            MAC:     if (mac_last) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, loop counters, accumulation and status registers
    always_ff @(posedge clk) begin
        if (reset) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            valid    <= 1'b0;
            mulError <= 1'b0;
            c_m      <= '0;
            c_n      <= '0;
            a_m_r    <= '0;
            a_n_r    <= '0;
            b_m_r    <= '0;
            b_n_r    <= '0;
            idx_i    <= '0;
            idx_j    <= '0;
            idx_k    <= '0;
            acc      <= '0;
            err      <= 1'b0;
            for (int e = 0; e < ELEMS; e++) begin
                a_mem[e] <= '0;
                b_mem[e] <= '0;
                c_mem[e] <= '0;
            end
        end else begin
            done <= (state == FIN);
            case (state)
                IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        valid    <= 1'b0;
                        mulError <= 1'b0;
                        c_m      <= '0;
                        c_n      <= '0;
                        a_m_r    <= a_m;
                        a_n_r    <= a_n;
                        b_m_r    <= b_m;
                        b_n_r    <= b_n;
                        idx_i    <= '0;
                        idx_j    <= '0;
                        idx_k    <= '0;
                        acc      <= '0;
                        err      <= 1'b0;
                        // Clearing here keeps elements outside c_m x c_n at zero
                        for (int e = 0; e < ELEMS; e++) begin
                            a_mem[e] <= matrixA[e*DATA_W +: DATA_W];
                            b_mem[e] <= matrixB[e*DATA_W +: DATA_W];
                            c_mem[e] <= '0;
                        end
                    end
                end
                CHECK: begin
                    err <= !dims_legal;
                end
                MAC: begin
                    if (k_last) begin
                        c_mem[c_idx] <= acc_new;
                        acc          <= '0;
                        idx_k        <= '0;
                        if (j_last) begin
                            idx_j <= '0;
                            idx_i <= idx_i + DIM_W'(1);
                        end else begin
                            idx_j <= idx_j + DIM_W'(1);
                        end
                    end else begin
                        acc   <= acc_new;
                        idx_k <= idx_k + DIM_W'(1);
                    end
                end
                FIN: begin
                    busy     <= 1'b0;
                    valid    <= !err;
                    mulError <= err;
                    c_m      <= err ? '0 : a_m_r;
                    c_n      <= err ? '0 : b_n_r;
                end
                default: ;
            endcase
        end
    end

    // Flatten the result array onto the output bus
    always_comb begin
        aMulB = '0;
        for (int e = 0; e < ELEMS; e++) begin
            aMulB[e*ACC_W +: ACC_W] = c_mem[e];
        end
    end

endmodule

// File: tb/tb_matrix_mul_seq.sv
// tb_matrix_mul_seq: directed and randomized requests checked against a
// plain-arithmetic matrix product model.
module tb_matrix_mul_seq;

    localparam int MAX_DIM = 5;
    localparam int DATA_W  = 8;
    localparam int ACC_W   = 16;
    localparam int DIM_W   = 3;
    localparam int ELEMS   = MAX_DIM * MAX_DIM;
    localparam int VA      = ELEMS * DATA_W;
    localparam int VC      = ELEMS * ACC_W;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [DIM_W-1:0] a_m, a_n, b_m, b_n;
    logic [VA-1:0]    matrixA, matrixB;
    logic             busy, done, valid, mulError;
    logic [DIM_W-1:0] c_m, c_n;
    logic [VC-1:0]    aMulB;

    int n_checks = 0;
    int n_pass   = 0;
    int ma [ELEMS];
    int mb [ELEMS];

    matrix_mul_seq #(
        .MAX_DIM(MAX_DIM), .DATA_W(DATA_W), .ACC_W(ACC_W), .DIM_W(DIM_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .a_m(a_m), .a_n(a_n), .b_m(b_m), .b_n(b_n),
        .matrixA(matrixA), .matrixB(matrixB),
        .busy(busy), .done(done), .valid(valid), .mulError(mulError),
        .c_m(c_m), .c_n(c_n), .aMulB(aMulB)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [VC-1:0] obs, input logic [VC-1:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: C(r,c) = sum_k A(r,k)*B(k,c), then wrapped or clamped to ACC_W bits
    function automatic logic [VC-1:0] model_c(input int am, input int an, input int bm,
                                               input int bn, output bit legal);
        logic [VC-1:0] res;
        longint s;
        longint lim;
        res   = '0;
        lim   = (longint'(1) << ACC_W) - 1;
        legal = (an == bm) && (am >= 1) && (am <= MAX_DIM) && (an >= 1) && (an <= MAX_DIM)
                && (bn >= 1) && (bn <= MAX_DIM);
        if (legal) begin
            for (int r = 0; r < am; r++) begin
                for (int c = 0; c < bn; c++) begin
                    s = 0;
                    for (int k = 0; k < an; k++) s += longint'(ma[r*MAX_DIM+k] * mb[k*MAX_DIM+c]);
`ifdef MATMUL_SATURATE_EN
                    if (s > lim) s = lim;
`else
                    s = s & lim;
`endif
                    res[(r*MAX_DIM+c)*ACC_W +: ACC_W] = s[ACC_W-1:0];
                end
            end
        end
        return res;
    endfunction

    task automatic drive_req(input int am, input int an, input int bm, input int bn);
        for (int e = 0; e < ELEMS; e++) begin
            matrixA[e*DATA_W +: DATA_W] = DATA_W'(ma[e]);
            matrixB[e*DATA_W +: DATA_W] = DATA_W'(mb[e]);
        end
        a_m = DIM_W'(am);
        a_n = DIM_W'(an);
        b_m = DIM_W'(bm);
        b_n = DIM_W'(bn);
    endtask

    task automatic fill_mats(input int mode, input int val);
        for (int e = 0; e < ELEMS; e++) begin
            ma[e] = (mode == 0) ? val : int'($urandom_range(0, 255));
            mb[e] = (mode == 0) ? val : int'($urandom_range(0, 255));
        end
    endtask

    task automatic set_test1();
        fill_mats(0, 0);
        ma[0] = 1; ma[1] = 2; ma[2] = 3;
        ma[5] = 3; ma[6] = 4; ma[7] = 5;
        mb[0] = 1; mb[1] = 0;
        mb[5] = 2; mb[6] = 1;
        mb[10] = 3; mb[11] = 2;
    endtask

    // Issue one request and check latency, status and result against the model.
    // With scramble set, inputs and start are randomized while the request runs.
    task automatic run_req(input int am, input int an, input int bm, input int bn,
                           input bit scramble, input string tag);
        bit            legal;
        logic [VC-1:0] exp_c;
        int            exp_lat;
        int            lat;
        bit            seen;
        exp_c   = model_c(am, an, bm, bn, legal);
        exp_lat = legal ? am * an * bn + 2 : 2;
        drive_req(am, an, bm, bn);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_val({tag, " busy_acc"}, VC'(busy), VC'(1));
        check_val({tag, " status_clr"}, VC'({valid, mulError}), VC'(0));
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 300) begin
            if (scramble) begin
                matrixA = {VA{1'b0}};
                for (int e = 0; e < ELEMS; e++) begin
                    matrixA[e*DATA_W +: DATA_W] = DATA_W'($urandom);
                    matrixB[e*DATA_W +: DATA_W] = DATA_W'($urandom);
                end
                a_m   = DIM_W'($urandom);
                a_n   = DIM_W'($urandom);
                b_m   = DIM_W'($urandom);
                b_n   = DIM_W'($urandom);
                start = 1'($urandom);
            end
            @(posedge clk);
            lat++;
            #1;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        check_val({tag, " latency"}, VC'(lat), VC'(exp_lat));
        check_val({tag, " valid"}, VC'(valid), VC'(legal));
        check_val({tag, " mulError"}, VC'(mulError), VC'(!legal));
        check_val({tag, " c_m"}, VC'(c_m), legal ? VC'(am) : VC'(0));
        check_val({tag, " c_n"}, VC'(c_n), legal ? VC'(bn) : VC'(0));
        check_val({tag, " aMulB"}, aMulB, exp_c);
        check_val({tag, " busy_done"}, VC'(busy), VC'(0));
        @(posedge clk); #1;
        check_val({tag, " done_1cyc"}, VC'(done), VC'(0));
        check_val({tag, " hold"}, aMulB, exp_c);
    endtask

    initial begin
        int am, an, bm, bn;
        int dcount;
        reset   = 1'b1;
        start   = 1'b0;
        a_m     = '0; a_n = '0; b_m = '0; b_n = '0;
        matrixA = '0;
        matrixB = '0;
        repeat (2) @(posedge clk);
        #1;
        check_val("reset status", VC'({busy, done, valid, mulError, c_m, c_n}), VC'(0));
        check_val("reset aMulB", aMulB, VC'(0));
        reset = 1'b0;
        @(posedge clk); #1;

        // Test 1: 2x3 x 3x2
        set_test1();
        run_req(2, 3, 3, 2, 1'b0, "t1");
        check_val("t1 c00", VC'(aMulB[0*ACC_W +: ACC_W]), VC'(14));
        check_val("t1 c01", VC'(aMulB[1*ACC_W +: ACC_W]), VC'(8));
        check_val("t1 c10", VC'(aMulB[5*ACC_W +: ACC_W]), VC'(26));
        check_val("t1 c11", VC'(aMulB[6*ACC_W +: ACC_W]), VC'(14));

        // Test 2: inner dimension mismatch
        run_req(2, 3, 2, 2, 1'b0, "t2");

        // Test 3: 1x5 x 5x1 all 255, overflow behaviour
        fill_mats(0, 255);
        run_req(1, 5, 5, 1, 1'b0, "t3");
`ifdef MATMUL_SATURATE_EN
        check_val("t3 c00", VC'(aMulB[ACC_W-1:0]), VC'(65535));
`else
        check_val("t3 c00", VC'(aMulB[ACC_W-1:0]), VC'(62981));
`endif

        // Test 4: 5x5 ones; inputs and start toggled while busy must be ignored
        fill_mats(0, 1);
        run_req(5, 5, 5, 5, 1'b1, "t4");
        check_val("t4 c44", VC'(aMulB[24*ACC_W +: ACC_W]), VC'(5));

        // Test 5: reset three cycles into Test 1
        set_test1();
        drive_req(2, 3, 3, 2);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_val("t5 status", VC'({busy, done, valid, mulError, c_m, c_n}), VC'(0));
        check_val("t5 aMulB", aMulB, VC'(0));
        dcount = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        check_val("t5 no_done", VC'(dcount), VC'(0));
        run_req(2, 3, 3, 2, 1'b0, "t5 rerun");

        // Reset wins over a simultaneous start
        start = 1'b1;
        reset = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        reset = 1'b0;
        check_val("rst_prio busy", VC'(busy), VC'(0));

        // Start in FIN is ignored, start in the following IDLE cycle is accepted
        set_test1();
        drive_req(2, 3, 3, 2);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (13) @(posedge clk);
        #1;
        check_val("fin busy", VC'(busy), VC'(1));
        drive_req(2, 3, 2, 2);
        start = 1'b1;
        @(posedge clk); #1;
        check_val("fin done", VC'(done), VC'(1));
        check_val("fin valid", VC'({valid, mulError}), VC'(2));
        check_val("fin busy_low", VC'(busy), VC'(0));
        @(posedge clk); #1;
        start = 1'b0;
        check_val("idle_acc busy", VC'(busy), VC'(1));
        repeat (2) @(posedge clk);
        #1;
        check_val("idle_acc done", VC'(done), VC'(1));
        check_val("idle_acc err", VC'({valid, mulError}), VC'(1));

        // Randomized requests, occasionally with illegal dimensions
        for (int t = 0; t < 20; t++) begin
            fill_mats(1, 0);
            if ($urandom_range(0, 3) == 0) begin
                am = int'($urandom_range(0, 7));
                an = int'($urandom_range(0, 7));
                bm = int'($urandom_range(0, 7));
                bn = int'($urandom_range(0, 7));
            end else begin
                am = int'($urandom_range(1, MAX_DIM));
                an = int'($urandom_range(1, MAX_DIM));
                bm = an;
                bn = int'($urandom_range(1, MAX_DIM));
            end
            run_req(am, an, bm, bn, 1'($urandom), $sformatf("rnd%0d", t));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
